// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR gate.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;
  logic w_g1;
  logic w_g2;

  // First half adder on the operand bits, second folds in the carry.
  assign w_p  = x ^ y;
  assign w_g1 = x & y;
  assign s    = w_p ^ cin;
  assign w_g2 = w_p & cin;
  assign cout = w_g1 | w_g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: shifts operands LSB first through one full-adder cell over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  fa_cell u_fa_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  // The final sum bit lands in the MSB on the same edge the result is published.
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_sum   <= w_res_next;
            r_carry <= w_cout;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, corner sequences and a result scoreboard.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;
  localparam int          Latency = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [W:0] exp;
    int         acc_edge;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vsum;
    logic         vcarry;
  } vec_t;

  serial_add_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: push on accept, pop on each done pulse. Edge index of the next posedge is cyc+1.
  always @(negedge clk) begin
    sb_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        fail_now("sb_unexpected_done");
      end else begin
        e = sb_q.pop_front();
        check("sb_result", 32'({carry, sum}), 32'(e.exp));
        check("sb_latency", 32'(cyc + 1 - e.acc_edge), 32'(Latency));
      end
    end
    if (!rst_n) begin
      sb_q.delete();
    end else if (start && !busy) begin
      e.exp      = {1'b0, a} + {1'b0, b};
      e.acc_edge = cyc + 1;
      sb_q.push_back(e);
    end
  end

  task automatic wait_done(output logic [W-1:0] rs, output logic rc, output int bcnt);
    logic got;
    got  = 1'b0;
    rs   = '0;
    rc   = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1;
        rs  = sum;
        rc  = carry;
        break;
      end
    end
    if (!got) begin
      fail_now("done_timeout");
    end else begin
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        output logic [W-1:0] rs, output logic rc, output int bcnt);
    @(posedge clk); #1;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(rs, rc, bcnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] rs;
    logic         rc;
    int           bcnt;
    int           ndone;
    int           prev;

    vecs[0] = '{va: 8'h00, vb: 8'h00, vsum: 8'h00, vcarry: 1'b0};
    vecs[1] = '{va: 8'hFF, vb: 8'h01, vsum: 8'h00, vcarry: 1'b1};
    vecs[2] = '{va: 8'hA5, vb: 8'h5A, vsum: 8'hFF, vcarry: 1'b0};
    vecs[3] = '{va: 8'h80, vb: 8'h80, vsum: 8'h00, vcarry: 1'b1};
    vecs[4] = '{va: 8'h0F, vb: 8'h01, vsum: 8'h10, vcarry: 1'b0};
    vecs[5] = '{va: 8'hFF, vb: 8'hFF, vsum: 8'hFE, vcarry: 1'b1};
    vecs[6] = '{va: 8'h7F, vb: 8'h01, vsum: 8'h80, vcarry: 1'b0};
    vecs[7] = '{va: 8'h12, vb: 8'h34, vsum: 8'h46, vcarry: 1'b0};

    // Reset with start already high: it must be accepted at the first released edge.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(rs, rc, bcnt);
    check("rel_sum", 32'(rs), 32'h07);
    check("rel_carry", 32'(rc), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, rs, rc, bcnt);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].vsum));
      check($sformatf("vec%0d_carry", i), 32'(rc), 32'(vecs[i].vcarry));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(W + 1));
    end

    // Start re-pulsed with new operands mid-RUN must be ignored.
    @(posedge clk); #1;
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    rs = '0;
    rc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        rs = sum;
        rc = carry;
      end
    end
    check("repulse_ndone", 32'(ndone), 32'd1);
    check("repulse_sum", 32'(rs), 32'hFF);
    check("repulse_carry", 32'(rc), 32'd0);
    check("hold_idle_sum", 32'(sum), 32'hFF);

    // Result must stay put through the next RUN.
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_run_sum", 32'(sum), 32'hFF);
    check("hold_run_carry", 32'(carry), 32'd0);
    wait_done(rs, rc, bcnt);
    check("hold_next_sum", 32'(rs), 32'h46);

    // Reset during RUN cycle 4 aborts with no done pulse.
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'h80, 8'h80, rs, rc, bcnt);
    check("after_abort_sum", 32'(rs), 32'h00);
    check("after_abort_carry", 32'(rc), 32'd1);

    // Start held high: back-to-back operations at the minimum period.
    @(posedge clk); #1;
    a = 8'h0F; b = 8'h01; start = 1'b1;
    ndone = 0;
    prev  = -1;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("b2b_sum", 32'(sum), 32'h10);
        check("b2b_carry", 32'(carry), 32'd0);
        if (prev >= 0) check("b2b_period", 32'(cyc - prev), 32'd10);
        prev = cyc;
      end
    end
    check("b2b_ndone", 32'(ndone), 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W:0]   expv;
      ra   = W'($urandom);
      rb   = W'($urandom);
      expv = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, rs, rc, bcnt);
      check("rand_result", 32'({rc, rs}), 32'(expv));
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
